// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Produces the latch enables and the bubble/flush controls for the PC, FD, DX,
// XM and MW latches. It detects load-use hazards, applies taken-branch flushes
// and runs the multi-cycle mult/div handshake, which has a timeout.
// The optional macro STALL_COUNTERS_EN adds the saturating stall counters
// cnt_md, cnt_lu and cnt_br.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned CNT_W      = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_insn,
  input  logic [31:0] dx_insn,
  input  logic        branch_taken,
  input  logic        md_ready,
  input  logic        md_exception_in,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        xm_en,
  output logic        mw_en,
  output logic        fd_flush,
  output logic        dx_flush,
  output logic        xm_bubble,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic        md_busy,
  output logic        md_exception
`ifdef STALL_COUNTERS_EN
  ,
  output logic [CNT_W-1:0] cnt_md,
  output logic [CNT_W-1:0] cnt_lu,
  output logic [CNT_W-1:0] cnt_br
`endif
);

  localparam int unsigned TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        r_state;
  logic [TW-1:0] r_md_cnt;

  logic [4:0] w_fd_op, w_fd_rd, w_fd_rs, w_fd_rt;
  logic [4:0] w_dx_op, w_dx_rd, w_dx_alu;
  logic       w_dx_mult, w_dx_div, w_dx_md, w_dx_lw;
  logic       w_fd_uses_rt, w_fd_uses_rd, w_load_use, w_timeout;
  logic       w_unused;

  assign w_fd_op  = fd_insn[31:27];
  assign w_fd_rd  = fd_insn[26:22];
  assign w_fd_rs  = fd_insn[21:17];
  assign w_fd_rt  = fd_insn[16:12];
  assign w_dx_op  = dx_insn[31:27];
  assign w_dx_rd  = dx_insn[26:22];
  assign w_dx_alu = dx_insn[6:2];

  // Instruction fields that the hazard logic never looks at.
  assign w_unused = ^{fd_insn[11:0], dx_insn[21:7], dx_insn[1:0]};

  assign w_dx_mult = (w_dx_op == OP_RTYPE) && (w_dx_alu == ALU_MULT);
  assign w_dx_div  = (w_dx_op == OP_RTYPE) && (w_dx_alu == ALU_DIV);
  assign w_dx_md   = w_dx_mult || w_dx_div;
  assign w_dx_lw   = (w_dx_op == OP_LW);

  assign w_fd_uses_rt = (w_fd_op == OP_RTYPE);
  assign w_fd_uses_rd = (w_fd_op == OP_SW) || (w_fd_op == OP_BNE) ||
                        (w_fd_op == OP_BLT) || (w_fd_op == OP_JR);

  // $0 is never a real dependency, so a load into it does not stall.
  assign w_load_use = w_dx_lw && (w_dx_rd != 5'd0) &&
                      ((w_dx_rd == w_fd_rs) ||
                       (w_fd_uses_rt && (w_dx_rd == w_fd_rt)) ||
                       (w_fd_uses_rd && (w_dx_rd == w_fd_rd)));

  assign w_timeout = (r_md_cnt == TW'(MD_TIMEOUT - 1));

  // Combinational control outputs from the FSM state and the current inputs;
  // everything is held at 0 while reset is low.
  always_comb begin
    pc_en        = reset;
    fd_en        = reset;
    dx_en        = reset;
    xm_en        = reset;
    mw_en        = reset;
    fd_flush     = 1'b0;
    dx_flush     = 1'b0;
    xm_bubble    = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    md_busy      = 1'b0;
    md_exception = 1'b0;
    if (reset) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_dx_md) begin
            md_ctrl_mult = w_dx_mult;
            md_ctrl_div  = w_dx_div;
            pc_en        = 1'b0;
            fd_en        = 1'b0;
            dx_en        = 1'b0;
            xm_bubble    = 1'b1;
          end else if (branch_taken) begin
            fd_flush = 1'b1;
            dx_flush = 1'b1;
          end else if (w_load_use) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            dx_flush = 1'b1;
          end
        end
        S_WAIT: begin
          md_busy = 1'b1;
          if (md_ready) begin
            md_exception = md_exception_in;
          end else if (w_timeout) begin
            md_exception = 1'b1;
          end else begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_en     = 1'b0;
            xm_bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Mult/div handshake FSM and its WAIT-cycle counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_md_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_md_cnt <= '0;
          if (w_dx_md) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (md_ready || w_timeout) begin
            r_state  <= S_IDLE;
            r_md_cnt <= '0;
          end else begin
            r_md_cnt <= r_md_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_md_cnt <= '0;
        end
      endcase
    end
  end

`ifdef STALL_COUNTERS_EN
  logic             w_md_cyc, w_br_cyc, w_lu_cyc;
  logic [CNT_W-1:0] r_cnt_md, r_cnt_lu, r_cnt_br;

  assign w_md_cyc = (r_state == S_WAIT) || ((r_state == S_IDLE) && w_dx_md);
  assign w_br_cyc = (r_state == S_IDLE) && !w_dx_md && branch_taken;
  assign w_lu_cyc = (r_state == S_IDLE) && !w_dx_md && !branch_taken && w_load_use;

  // Saturating event counters for mult/div cycles, load-use stalls and branch flushes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt_md <= '0;
      r_cnt_lu <= '0;
      r_cnt_br <= '0;
    end else begin
      if (w_md_cyc && (r_cnt_md != '1)) r_cnt_md <= r_cnt_md + 1'b1;
      if (w_lu_cyc && (r_cnt_lu != '1)) r_cnt_lu <= r_cnt_lu + 1'b1;
      if (w_br_cyc && (r_cnt_br != '1)) r_cnt_br <= r_cnt_br + 1'b1;
    end
  end

  assign cnt_md = r_cnt_md;
  assign cnt_lu = r_cnt_lu;
  assign cnt_br = r_cnt_br;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (default MD_TIMEOUT=40).
module tb_pipe_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fd_insn = '0;
  logic [31:0] dx_insn = '0;
  logic        branch_taken = 1'b0;
  logic        md_ready = 1'b0;
  logic        md_exception_in = 1'b0;
  logic pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_bubble;
  logic md_ctrl_mult, md_ctrl_div, md_busy, md_exception;
`ifdef STALL_COUNTERS_EN
  logic [31:0] cnt_md, cnt_lu, cnt_br;
`endif

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn),
    .branch_taken(branch_taken), .md_ready(md_ready),
    .md_exception_in(md_exception_in),
    .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
    .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_bubble(xm_bubble),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_busy(md_busy), .md_exception(md_exception)
`ifdef STALL_COUNTERS_EN
    , .cnt_md(cnt_md), .cnt_lu(cnt_lu), .cnt_br(cnt_br)
`endif
  );

  always #5 clock = ~clock;

  // Output vector order: pc fd dx xm mw | fd_flush dx_flush xm_bubble | mult div | busy exc
  localparam logic [11:0] ZERO    = 12'b00000_000_00_00;
  localparam logic [11:0] DEF     = 12'b11111_000_00_00;
  localparam logic [11:0] START_M = 12'b00011_001_10_00;
  localparam logic [11:0] START_D = 12'b00011_001_01_00;
  localparam logic [11:0] WAITS   = 12'b00011_001_00_10;
  localparam logic [11:0] REL     = 12'b11111_000_00_10;
  localparam logic [11:0] REL_EXC = 12'b11111_000_00_11;
  localparam logic [11:0] LU      = 12'b00111_010_00_00;
  localparam logic [11:0] BR      = 12'b11111_110_00_00;

  // Encodings: op[31:27] rd[26:22] rs[21:17] rt[16:12] shamt[11:7] alu[6:2]
  localparam logic [31:0] NOP      = 32'd0;
  localparam logic [31:0] MULT     = {5'b00000, 5'd1, 5'd2, 5'd3, 5'd0, 5'b00110, 2'b00};
  localparam logic [31:0] DIV      = {5'b00000, 5'd4, 5'd2, 5'd3, 5'd0, 5'b00111, 2'b00};
  localparam logic [31:0] LW5      = {5'b01000, 5'd5, 5'd1, 17'd0};
  localparam logic [31:0] LW0      = {5'b01000, 5'd0, 5'd1, 17'd0};
  localparam logic [31:0] ADD_RS5  = {5'b00000, 5'd6, 5'd5, 5'd7, 12'd0};
  localparam logic [31:0] ADD_RT5  = {5'b00000, 5'd6, 5'd7, 5'd5, 12'd0};
  localparam logic [31:0] ADD_RS0  = {5'b00000, 5'd6, 5'd0, 5'd7, 12'd0};
  localparam logic [31:0] SW_RD5   = {5'b00111, 5'd5, 5'd1, 17'd0};
  localparam logic [31:0] ADDI_RT5 = {5'b00101, 5'd6, 5'd1, 5'd5, 12'd0};

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic go(input logic [31:0] dx, input logic [31:0] fd, input logic br,
                    input logic rdy, input logic exc);
    dx_insn = dx; fd_insn = fd; branch_taken = br;
    md_ready = rdy; md_exception_in = exc;
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] expv);
    logic [11:0] obs;
    obs = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_bubble,
           md_ctrl_mult, md_ctrl_div, md_busy, md_exception};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

`ifdef STALL_COUNTERS_EN
  task automatic chk_cnt(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
`endif

  initial begin
    // Reset gating: a mult sitting in DX must not produce anything.
    go(MULT, NOP, 1'b1, 1'b1, 1'b1);
    #1 chk("reset_all_zero", ZERO);
    adv();
    go(NOP, NOP, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1 chk("idle_default", DEF);

    // Mult, md_ready ignored in start cycle, branch ignored in WAIT, ready on 3rd WAIT cycle.
    adv(); go(MULT, NOP, 1'b0, 1'b1, 1'b0); chk("mult_start", START_M);
    adv(); go(MULT, NOP, 1'b1, 1'b0, 1'b0); chk("mult_wait1_br_ignored", WAITS);
    adv(); go(MULT, NOP, 1'b0, 1'b0, 1'b0); chk("mult_wait2", WAITS);
    adv(); go(MULT, NOP, 1'b0, 1'b1, 1'b0); chk("mult_release", REL);
    adv(); go(NOP, NOP, 1'b0, 1'b0, 1'b0); chk("mult_after_idle", DEF);

    // Load-use on rs, then the bubble clears it.
    adv(); go(LW5, ADD_RS5, 1'b0, 1'b0, 1'b0); chk("lu_rs", LU);
    adv(); go(NOP, ADD_RS5, 1'b0, 1'b0, 1'b0); chk("lu_cleared", DEF);
`ifdef STALL_COUNTERS_EN
    chk_cnt("cnt_md", cnt_md, 32'd4);
    chk_cnt("cnt_lu", cnt_lu, 32'd1);
    chk_cnt("cnt_br", cnt_br, 32'd0);
`endif

    adv(); go(LW5, ADD_RT5, 1'b0, 1'b0, 1'b0);  chk("lu_rt_rtype", LU);
    adv(); go(LW5, SW_RD5, 1'b0, 1'b0, 1'b0);   chk("lu_rd_sw", LU);
    adv(); go(LW5, ADDI_RT5, 1'b0, 1'b0, 1'b0); chk("no_lu_itype_rt", DEF);
    adv(); go(LW0, ADD_RS0, 1'b0, 1'b0, 1'b0);  chk("no_lu_r0", DEF);
    adv(); go(LW5, ADD_RS5, 1'b1, 1'b0, 1'b0);  chk("branch_over_lu", BR);
    adv(); go(NOP, NOP, 1'b1, 1'b0, 1'b0);      chk("branch_only", BR);

    // Exception mirrored on release, then back-to-back div gets a fresh pulse.
    adv(); go(MULT, NOP, 1'b0, 1'b0, 1'b0); chk("mult2_start", START_M);
    adv(); go(MULT, NOP, 1'b0, 1'b1, 1'b1); chk("mult2_release_exc", REL_EXC);
    adv(); go(DIV, NOP, 1'b0, 1'b0, 1'b0);  chk("div_b2b_start", START_D);
    for (int i = 1; i < 40; i++) begin
      adv(); go(DIV, NOP, 1'b0, 1'b0, 1'b0); chk("div_timeout_wait", WAITS);
    end
    adv(); go(DIV, NOP, 1'b0, 1'b0, 1'b0); chk("div_timeout_release", REL_EXC);
    adv(); go(NOP, NOP, 1'b0, 1'b0, 1'b0); chk("div_timeout_idle", DEF);

    // Ready coinciding with the timeout cycle counts as ready.
    adv(); go(DIV, NOP, 1'b0, 1'b0, 1'b0); chk("div2_start", START_D);
    for (int i = 1; i < 40; i++) begin
      adv(); go(DIV, NOP, 1'b0, 1'b0, 1'b0); chk("div2_wait", WAITS);
    end
    adv(); go(DIV, NOP, 1'b0, 1'b1, 1'b0); chk("div2_ready_at_timeout", REL);
    adv(); go(NOP, NOP, 1'b0, 1'b0, 1'b0); chk("div2_idle", DEF);

    // Asynchronous reset in the middle of WAIT.
    adv(); go(MULT, NOP, 1'b0, 1'b0, 1'b0); chk("mult3_start", START_M);
    adv(); go(MULT, NOP, 1'b0, 1'b0, 1'b0); chk("mult3_wait1", WAITS);
    reset = 1'b0;
    #1 chk("async_reset_zero", ZERO);
    adv(); chk("reset_held_zero", ZERO);
`ifdef STALL_COUNTERS_EN
    chk_cnt("cnt_md_rst", cnt_md, 32'd0);
    chk_cnt("cnt_lu_rst", cnt_lu, 32'd0);
    chk_cnt("cnt_br_rst", cnt_br, 32'd0);
`endif
    go(NOP, NOP, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1 chk("after_reset_idle", DEF);
    adv(); go(NOP, NOP, 1'b0, 1'b1, 1'b1); chk("after_reset_no_exc", DEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
